// File: rtl/argmax_pkg.sv
// Shared types and helpers for the argmax classifier output stage.
package argmax_pkg;

  // Frame-level control states
  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_e;

  // Ceiling log2 that never returns less than one bit
  function automatic int clog2_min1(input int value);
    int bits;
    bits = $clog2(value);
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/argmax_classifier_score_gt.sv
// Strict greater-than compare of two scores, signed or unsigned by parameter.
module score_gt #(
  parameter int SCORE_W      = 32,
  parameter bit SCORE_SIGNED = 1'b0
) (
  input  logic [SCORE_W-1:0] a,
  input  logic [SCORE_W-1:0] b,
  output logic               gt
);

  // a > b, interpreting both operands as two's complement when signed
  always_comb begin
    if (SCORE_SIGNED) begin
      gt = $signed(a) > $signed(b);
    end else begin
      gt = a > b;
    end
  end

endmodule

// File: rtl/argmax_classifier.sv
// Streaming argmax over one frame of class scores (one score per beat).
// Emits the winning class index and score once per frame, with an error
// flag when the frame length differs from NUM_CLASSES.
// Optional feature macro: ARGMAX_TOP2_EN adds second-best index and the
// best-minus-second margin.
module argmax_classifier
  import argmax_pkg::*;
#(
  parameter int NUM_CLASSES  = 10,
  parameter int SCORE_W      = 32,
  parameter bit SCORE_SIGNED = 1'b0,
  parameter int CLS_W        = clog2_min1(NUM_CLASSES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_score,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLS_W-1:0]   out_class,
  output logic [SCORE_W-1:0] out_score,
  output logic               out_err
`ifdef ARGMAX_TOP2_EN
  ,
  output logic [CLS_W-1:0]   out_class2,
  output logic [SCORE_W:0]   out_margin
`endif
);

  localparam logic [CLS_W-1:0] LAST_IDX   = CLS_W'(NUM_CLASSES - 1);
  localparam logic [CLS_W-1:0] SECOND_IDX = CLS_W'(1);

  state_e               state_q, state_d;
  logic [CLS_W-1:0]     idx_q, idx_d;
  logic [SCORE_W-1:0]   best_q, best_d;
  logic [CLS_W-1:0]     best_idx_q, best_idx_d;
  logic [CLS_W-1:0]     out_class_q, out_class_d;
  logic [SCORE_W-1:0]   out_score_q, out_score_d;
  logic                 out_err_q, out_err_d;

  logic                 accept;
  logic                 at_end;
  logic                 frame_close;
  logic                 best_gt;
  logic [SCORE_W-1:0]   cand_score;
  logic [CLS_W-1:0]     cand_idx;

`ifdef ARGMAX_TOP2_EN
  logic [SCORE_W-1:0]   second_q, second_d;
  logic [CLS_W-1:0]     second_idx_q, second_idx_d;
  logic [CLS_W-1:0]     out_class2_q, out_class2_d;
  logic [SCORE_W:0]     out_margin_q, out_margin_d;
  logic                 second_gt;
  logic [SCORE_W-1:0]   cand2_score;
  logic [CLS_W-1:0]     cand2_idx;
  logic [SCORE_W:0]     best_ext;
  logic [SCORE_W:0]     second_ext;
  logic [SCORE_W:0]     margin;
`endif

  assign accept      = in_valid && in_ready;
  assign at_end      = (idx_q == LAST_IDX);
  assign frame_close = in_last || at_end;

  score_gt #(
    .SCORE_W     (SCORE_W),
    .SCORE_SIGNED(SCORE_SIGNED)
  ) u_best_gt (
    .a (in_score),
    .b (best_q),
    .gt(best_gt)
  );

`ifdef ARGMAX_TOP2_EN
  score_gt #(
    .SCORE_W     (SCORE_W),
    .SCORE_SIGNED(SCORE_SIGNED)
  ) u_second_gt (
    .a (in_score),
    .b (second_q),
    .gt(second_gt)
  );
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: open on first beat, close on last/count, release on handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = in_last ? DONE : ACC;
      ACC:  if (accept && frame_close) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on the registered state only
  always_comb begin
    in_ready  = (state_q != DONE);
    out_valid = (state_q == DONE);
  end

  // Running maximum, beat counter and result capture on frame close
  always_comb begin
    idx_d       = idx_q;
    best_d      = best_q;
    best_idx_d  = best_idx_q;
    out_class_d = out_class_q;
    out_score_d = out_score_q;
    out_err_d   = out_err_q;
    cand_score  = best_gt ? in_score : best_q;
    cand_idx    = best_gt ? idx_q : best_idx_q;
`ifdef ARGMAX_TOP2_EN
    second_d     = second_q;
    second_idx_d = second_idx_q;
    out_class2_d = out_class2_q;
    out_margin_d = out_margin_q;
    if (best_gt) begin
      cand2_score = best_q;
      cand2_idx   = best_idx_q;
    end else if ((idx_q == SECOND_IDX) || second_gt) begin
      cand2_score = in_score;
      cand2_idx   = idx_q;
    end else begin
      cand2_score = second_q;
      cand2_idx   = second_idx_q;
    end
    if (SCORE_SIGNED) begin
      best_ext   = {cand_score[SCORE_W-1], cand_score};
      second_ext = {cand2_score[SCORE_W-1], cand2_score};
    end else begin
      best_ext   = {1'b0, cand_score};
      second_ext = {1'b0, cand2_score};
    end
    margin = best_ext - second_ext;
`endif
    if (accept) begin
      case (state_q)
        IDLE: begin
          best_d     = in_score;
          best_idx_d = '0;
          idx_d      = SECOND_IDX;
`ifdef ARGMAX_TOP2_EN
          second_d     = '0;
          second_idx_d = '0;
`endif
          if (in_last) begin
            out_class_d = '0;
            out_score_d = in_score;
            out_err_d   = 1'b1;
            idx_d       = '0;
`ifdef ARGMAX_TOP2_EN
            out_class2_d = '0;
            out_margin_d = '0;
`endif
          end
        end
        ACC: begin
          best_d     = cand_score;
          best_idx_d = cand_idx;
          idx_d      = idx_q + CLS_W'(1);
`ifdef ARGMAX_TOP2_EN
          second_d     = cand2_score;
          second_idx_d = cand2_idx;
`endif
          if (frame_close) begin
            out_class_d = cand_idx;
            out_score_d = cand_score;
            out_err_d   = (in_last != at_end);
            idx_d       = '0;
`ifdef ARGMAX_TOP2_EN
            out_class2_d = cand2_idx;
            out_margin_d = margin;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      out_class_q  <= '0;
      out_score_q  <= '0;
      out_err_q    <= 1'b0;
`ifdef ARGMAX_TOP2_EN
      second_q     <= '0;
      second_idx_q <= '0;
      out_class2_q <= '0;
      out_margin_q <= '0;
`endif
    end else begin
      idx_q        <= idx_d;
      best_q       <= best_d;
      best_idx_q   <= best_idx_d;
      out_class_q  <= out_class_d;
      out_score_q  <= out_score_d;
      out_err_q    <= out_err_d;
`ifdef ARGMAX_TOP2_EN
      second_q     <= second_d;
      second_idx_q <= second_idx_d;
      out_class2_q <= out_class2_d;
      out_margin_q <= out_margin_d;
`endif
    end
  end

  assign out_class = out_class_q;
  assign out_score = out_score_q;
  assign out_err   = out_err_q;
`ifdef ARGMAX_TOP2_EN
  assign out_class2 = out_class2_q;
  assign out_margin = out_margin_q;
`endif

endmodule
